dec_syndrome: RTL

Receive-side syndrome calculator for the Reed-Solomon link. It consumes the `ENC_SYM`-symbol-per-beat codeword stream produced by the encoder and tracks codeword boundaries, including codewords that straddle beats. For each completed codeword it emits all `RSC_PAR_LEN` syndromes plus an error flag, and it keeps a saturating count of erroneous codewords. It is the first stage of the future decoder; key-equation solving and error location come downstream.

---
 rtl/dec_syndrome_pkg.sv | 45 ++++
 rtl/dec_syn_cell.sv | 53 +++++
 rtl/dec_syndrome.sv | 66 ++++++
 3 files changed

// File: rtl/dec_syndrome_pkg.sv
// Shared Reed-Solomon link parameters and the GF(2^m) constant helpers used to
// build the alpha-power multiplier tables at elaboration time.
package dec_syndrome_pkg;

   localparam int EGF_DIM     = 8;
   localparam int ENC_SYM     = 8;
   localparam int RSC_COD_LEN = 255;
   localparam int RSC_PAR_LEN = 16;
   localparam int RSC_FCR     = 0;
   localparam logic [EGF_DIM:0] EGF_PRI_POL = 9'h11D;

   localparam int POS_W = $clog2(RSC_COD_LEN);
   localparam int K_W   = $clog2(ENC_SYM + 1);
   localparam int GF_ORD = (2 ** EGF_DIM) - 1;

   typedef logic [EGF_DIM-1:0] sym_t;

   function automatic sym_t gf_mul(input sym_t a, input sym_t b);
      sym_t p;
      sym_t x;
      p = '0;
      x = a;
      for (int i = 0; i < EGF_DIM; i++) begin
         if (b[i]) p = p ^ x;
         x = x[EGF_DIM-1] ? ((x << 1) ^ EGF_PRI_POL[EGF_DIM-1:0]) : (x << 1);
      end
      return p;
   endfunction

   function automatic sym_t gf_pow(input int n);
      sym_t r;
      r = sym_t'(1);
      for (int i = 0; i < (n % GF_ORD); i++) r = gf_mul(r, sym_t'(2));
      return r;
   endfunction

   // Row n holds alpha^(jp*n) for n = 0..ENC_SYM.
   function automatic logic [(ENC_SYM+1)*EGF_DIM-1:0] alpha_row(input int jp);
      logic [(ENC_SYM+1)*EGF_DIM-1:0] row;
      row = '0;
      for (int n = 0; n <= ENC_SYM; n++) row[n*EGF_DIM +: EGF_DIM] = gf_pow(jp * n);
      return row;
   endfunction

endpackage

// File: rtl/dec_syn_cell.sv
// One syndrome accumulator: Horner update over a full beat, k-selected finish
// value for an end beat, and the masked tail that seeds the next codeword.
module dec_syn_cell
   import dec_syndrome_pkg::*;
#(
   parameter int JP = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       beat,
   input  logic                       end_beat,
   input  logic [K_W-1:0]             k,
   input  logic [ENC_SYM*EGF_DIM-1:0] data,
   output sym_t                       fin
);

   localparam logic [(ENC_SYM+1)*EGF_DIM-1:0] POW = alpha_row(JP);

   sym_t acc;
   sym_t tail;
   sym_t fin_k [1:ENC_SYM];

   // fin_k[ENC_SYM] doubles as the mid-beat update.
   always_comb begin
      tail = '0;
      fin  = '0;
      for (int kk = 1; kk <= ENC_SYM; kk++) begin
         fin_k[kk] = gf_mul(acc, POW[kk*EGF_DIM +: EGF_DIM]);
         for (int i = 0; i < ENC_SYM; i++) begin
            if (i < kk)
               fin_k[kk] = fin_k[kk] ^ gf_mul(data[i*EGF_DIM +: EGF_DIM],
                                              POW[(kk-1-i)*EGF_DIM +: EGF_DIM]);
         end
      end
      for (int i = 0; i < ENC_SYM; i++) begin
         if (i >= int'(k))
            tail = tail ^ gf_mul(data[i*EGF_DIM +: EGF_DIM],
                                 POW[(ENC_SYM-1-i)*EGF_DIM +: EGF_DIM]);
      end
      for (int kk = 1; kk <= ENC_SYM; kk++) begin
         if (int'(k) == kk) fin = fin_k[kk];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (beat) begin
         acc <= end_beat ? tail : fin_k[ENC_SYM];
      end
   end

endmodule

// File: rtl/dec_syndrome.sv
// Receive-side syndrome calculator: tracks codeword position across beats and
// registers the full syndrome set, error flag and saturating error count.
module dec_syndrome
   import dec_syndrome_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enc_valid,
   input  logic [ENC_SYM*EGF_DIM-1:0]     enc_data,
   output logic                           syn_valid,
   output logic [RSC_PAR_LEN*EGF_DIM-1:0] syn_data,
   output logic                           syn_error,
   output logic [ERR_CNT_W-1:0]           err_count
);

   logic [POS_W-1:0]               pos;
   logic [POS_W-1:0]               pos_nxt;
   logic [POS_W:0]                 rem;
   logic                           end_beat;
   logic [K_W-1:0]                 k;
   logic [RSC_PAR_LEN*EGF_DIM-1:0] fin_all;
   logic                           fin_nz;

   always_comb begin
      rem      = (POS_W+1)'(RSC_COD_LEN) - {1'b0, pos};
      end_beat = (rem <= (POS_W+1)'(ENC_SYM));
      k        = rem[K_W-1:0];
      pos_nxt  = end_beat ? (POS_W'(ENC_SYM) - POS_W'(k)) : (pos + POS_W'(ENC_SYM));
      fin_nz   = |fin_all;
   end

   for (genvar j = 0; j < RSC_PAR_LEN; j++) begin : g_cell
      dec_syn_cell #(
         .JP (RSC_FCR + j)
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .beat     (enc_valid),
         .end_beat (end_beat),
         .k        (k),
         .data     (enc_data),
         .fin      (fin_all[j*EGF_DIM +: EGF_DIM])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos       <= '0;
         syn_valid <= 1'b0;
         syn_data  <= '0;
         syn_error <= 1'b0;
         err_count <= '0;
      end else begin
         syn_valid <= enc_valid && end_beat;
         if (enc_valid) pos <= pos_nxt;
         if (enc_valid && end_beat) begin
            syn_data  <= fin_all;
            syn_error <= fin_nz;
            if (fin_nz && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
         end
      end
   end

endmodule
